// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain_if
// Description : Valid/ready stream bundle around a pipe_reg_chain: upstream
//               input side, downstream output side and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               din;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               dout;
    logic [$clog2(DEPTH+1)-1:0]     count;

    // The pipeline itself: consumes the upstream word and downstream ready.
    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout,
        output count
    );

    // The environment around the pipeline: produces words, accepts results.
    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout,
        input  count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : DEPTH-stage stallable, flushable register pipeline with
//               per-stage valid bits and bubble collapse. Each stage loads
//               from its predecessor whenever it is empty or its own contents
//               are moving on, so gaps fill even while the output is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_reg_chain_if.slave  bus
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][WIDTH-1:0]  r_d;
    logic [c_CNT_W-1:0]           r_count;

    logic [DEPTH-1:0]             w_acc;
    logic [DEPTH-1:0]             w_src_v;
    logic [DEPTH-1:0][WIDTH-1:0]  w_src_d;
    logic [DEPTH-1:0]             w_v_next;
    logic [DEPTH-1:0]             w_load;
    logic [c_CNT_W-1:0]           w_cnt_next;

    // Per-stage source selection and accept chain, rippling back from the output.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_src_v[i] = bus.in_valid;
            assign w_src_d[i] = bus.din;
        end else begin : g_body
            assign w_src_v[i] = r_v[i-1];
            assign w_src_d[i] = r_d[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign w_acc[i] = !r_v[i] | bus.out_ready;
        end else begin : g_mid
            assign w_acc[i] = !r_v[i] | w_acc[i+1];
        end
    end

    // Next valid vector, data load enables and the occupancy it implies.
    always_comb begin
        w_v_next   = '0;
        w_load     = '0;
        w_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Data only moves with a real word, so bubbles never toggle d.
            w_load[i]   = !flush & w_acc[i] & w_src_v[i];
            w_v_next[i] = flush ? 1'b0 : (w_acc[i] ? w_src_v[i] : r_v[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next = w_cnt_next + c_CNT_W'(w_v_next[i]);
        end
    end

    // Stage registers and registered occupancy; reset overrides flush and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= RST_VAL;
            end
        end else begin
            r_v     <= w_v_next;
            r_count <= w_cnt_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_d[i] <= w_src_d[i];
                end
            end
        end
    end

    // Input is refused during a flush so that cycle's word is never captured.
    assign bus.in_ready  = w_acc[0] & !flush;
    assign bus.out_valid = r_v[DEPTH-1];
    assign bus.dout      = r_d[DEPTH-1];
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_chain
// Description : Directed bench for pipe_reg_chain (DEPTH=3, WIDTH=8,
//               RST_VAL=8'hA5) with a word-position model checked each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;
    localparam int               WIDTH   = 8;
    localparam int               DEPTH   = 3;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_reg_chain #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: in-flight words as (stage position, data), oldest first.
    int               mpos[$];
    logic [WIDTH-1:0] mdat[$];
    logic [WIDTH-1:0] mlast = RST_VAL;

    // Each word advances one stage unless the slot ahead is still taken after
    // the word in front has moved; position DEPTH means it left the pipe.
    function automatic void next_positions(output int np[$]);
        int ahead;
        int n;
        ahead = bus.out_ready ? DEPTH + 1 : DEPTH;
        np = {};
        foreach (mpos[k]) begin
            n = (mpos[k] + 1 < ahead) ? mpos[k] + 1 : mpos[k];
            np.push_back(n);
            ahead = n;
        end
    endfunction

    function automatic bit model_in_ready();
        int np[$];
        next_positions(np);
        return !flush && ((np.size() == 0) || (np[np.size()-1] > 0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update on every clock edge.
    always @(posedge clk) begin
        int  np[$];
        bit  take;
        if (rst) begin
            mpos  = {};
            mdat  = {};
            mlast = RST_VAL;
        end else if (flush) begin
            mpos = {};
            mdat = {};
        end else begin
            take = bus.in_valid && model_in_ready();
            next_positions(np);
            foreach (np[k]) begin
                if (np[k] == DEPTH - 1 && mpos[k] != DEPTH - 1) mlast = mdat[k];
            end
            mpos = np;
            if (mpos.size() > 0 && mpos[0] == DEPTH) begin
                void'(mpos.pop_front());
                void'(mdat.pop_front());
            end
            if (take) begin
                mpos.push_back(0);
                mdat.push_back(bus.din);
                if (DEPTH == 1) mlast = bus.din;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", 32'(bus.out_valid),
                  32'((mpos.size() > 0) && (mpos[0] == DEPTH - 1)));
            check("m_dout",     32'(bus.dout),     32'(mlast));
            check("m_count",    32'(bus.count),    32'(mpos.size()));
            check("m_in_ready", 32'(bus.in_ready), 32'(model_in_ready()));
        end
    end

    task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input logic r, output bit acc);
        bus.in_valid  = iv;
        bus.din       = d;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = r;
        @(negedge clk);
        acc = iv && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a;
        int idx;
        bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b1; flush = 1'b0; rst = 1'b1;

        // Reset
        step(0, 0, 1, 0, 1, a);
        chk_en = 1'b1;
        step(0, 0, 1, 0, 1, a);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_dout",      32'(bus.dout),      32'h A5);
        check("rst_count",     32'(bus.count),     0);
        check("rst_in_ready",  32'(bus.in_ready),  1);

        // Unstalled stream 1..8
        step(1, 8'd1, 1, 0, 0, a);
        step(1, 8'd2, 1, 0, 0, a);
        check("stream_not_yet", 32'(bus.out_valid), 0);
        step(1, 8'd3, 1, 0, 0, a);
        check("stream_first_v", 32'(bus.out_valid), 1);
        check("stream_first_d", 32'(bus.dout), 1);
        step(1, 8'd4, 1, 0, 0, a);
        check("stream_second_d", 32'(bus.dout), 2);
        for (int v = 5; v <= 8; v++) step(1, 8'(v), 1, 0, 0, a);
        step(0, 0, 1, 0, 0, a);
        step(0, 0, 1, 0, 0, a);
        check("stream_last_d", 32'(bus.dout), 8);
        step(0, 0, 1, 0, 0, a);
        check("stream_drained_v", 32'(bus.out_valid), 0);
        check("stream_drained_c", 32'(bus.count), 0);

        // Backpressure: 5 words 11..15 held until accepted
        idx = 0;
        repeat (3) begin step(1, 8'(11 + idx), 0, 0, 0, a); if (a) idx++; end
        check("bp_accepted", 32'(idx), 3);
        check("bp_count",    32'(bus.count), 3);
        check("bp_in_ready", 32'(bus.in_ready), 0);
        repeat (2) begin step(1, 8'(11 + idx), 0, 0, 0, a); if (a) idx++; end
        check("bp_stall_d", 32'(bus.dout), 11);
        check("bp_stall_v", 32'(bus.out_valid), 1);
        step(1, 8'(11 + idx), 1, 0, 0, a); if (a) idx++;
        check("bp_release_d", 32'(bus.dout), 12);
        for (int c = 0; c < 20 && idx < 5; c++) begin
            step(1, 8'(11 + idx), 1, 0, 0, a); if (a) idx++;
        end
        check("bp_all_sent", 32'(idx), 5);
        repeat (4) step(0, 0, 1, 0, 0, a);
        check("bp_last_d", 32'(bus.dout), 15);

        // Bubble collapse
        step(1, 8'd21, 0, 0, 0, a);
        step(0, 0,     0, 0, 0, a);
        step(1, 8'd22, 0, 0, 0, a);
        step(0, 0,     0, 0, 0, a);
        check("bub_count", 32'(bus.count), 2);
        check("bub_v",     32'(bus.out_valid), 1);
        check("bub_d",     32'(bus.dout), 21);
        step(0, 0, 1, 0, 0, a);
        check("bub_next_d", 32'(bus.dout), 22);
        check("bub_next_c", 32'(bus.count), 1);
        step(0, 0, 1, 0, 0, a);

        // Flush with a full pipe
        step(1, 8'd31, 0, 0, 0, a);
        step(1, 8'd32, 0, 0, 0, a);
        step(1, 8'd33, 0, 0, 0, a);
        check("fl_full", 32'(bus.count), 3);
        step(1, 8'd34, 1, 1, 0, a);
        check("fl_no_accept", 32'(a), 0);
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("fl_count",    32'(bus.count), 0);
        check("fl_v",        32'(bus.out_valid), 0);
        check("fl_d_kept",   32'(bus.dout), 31);
        check("fl_in_ready", 32'(bus.in_ready), 1);
        step(0, 0, 1, 0, 0, a);

        // Reset mid-stream, then a fresh stream
        step(1, 8'd41, 0, 0, 0, a);
        step(1, 8'd42, 0, 0, 0, a);
        check("mr_count2", 32'(bus.count), 2);
        step(1, 8'd43, 0, 1, 1, a);
        check("mr_count", 32'(bus.count), 0);
        check("mr_dout",  32'(bus.dout), 32'h A5);
        check("mr_v",     32'(bus.out_valid), 0);
        for (int v = 51; v <= 54; v++) begin
            step(1, 8'(v), 1, 0, 0, a);
            if (v == 53) check("mr_first_d", 32'(bus.dout), 51);
        end
        step(0, 0, 1, 0, 0, a);
        step(0, 0, 1, 0, 0, a);
        check("mr_last_d", 32'(bus.dout), 54);
        check("mr_last_v", 32'(bus.out_valid), 1);
        step(0, 0, 1, 0, 0, a);
        check("mr_empty", 32'(bus.count), 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
